// File: rtl/i2c_pkg.sv
// i2c_pkg: shared constants for the I2C target endpoint.
// State encoding, ACK/NACK line levels, R/W bit values and a 3-sample
// majority helper used by the optional glitch filter (I2C_SLV_GLITCH_FILTER_EN).
`timescale 1ns/1ps
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    PTR       = 4'd3,
    PTR_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    RDATA_ACK = 4'd8,
    WAIT_STOP = 4'd9
  } state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // Majority vote of three samples.
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/i2c_slave_if.sv
// i2c_slave_if: register-port bundle between the I2C target and a local
// register file, plus the FSM state for observation.
// Handshake: reg_wr_en and reg_rd_req are single-cycle strobes with no
// back-pressure; addr/data are valid in the strobe cycle, and the register
// file must present reg_rd_data exactly one clock after reg_rd_req.
`timescale 1ns/1ps
interface i2c_slave_if;
  import i2c_pkg::*;

  logic       reg_wr_en;
  logic [7:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic       reg_rd_req;
  logic [7:0] reg_rd_addr;
  logic [7:0] reg_rd_data;
  state_t     dbg_state;

  // I2C target side: issues strobes, consumes read data.
  modport master (
    output reg_wr_en, reg_wr_addr, reg_wr_data,
    output reg_rd_req, reg_rd_addr,
    input  reg_rd_data,
    output dbg_state
  );

  // Register file side.
  modport slave (
    input  reg_wr_en, reg_wr_addr, reg_wr_data,
    input  reg_rd_req, reg_rd_addr,
    output reg_rd_data,
    input  dbg_state
  );
endinterface

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: 2-FF synchronizers for SCL and SDA, optional 3-sample
// majority filter (I2C_SLV_GLITCH_FILTER_EN), and edge / START / STOP
// detection on the conditioned levels. Lines idle high, so all flops reset to 1.
`timescale 1ns/1ps
module i2c_line_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_lvl,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync_q, scl_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;
  logic       scl_prev_q, scl_prev_d;
  logic       sda_prev_q, sda_prev_d;
  logic       scl_cur, sda_cur;

  // Synchronizer shift stages.
  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_in};
    sda_sync_d = {sda_sync_q[0], sda_in};
  end

  // Synchronizer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
    end
  end

`ifdef I2C_SLV_GLITCH_FILTER_EN
  logic [2:0] scl_win_q, scl_win_d;
  logic [2:0] sda_win_q, sda_win_d;
  logic       scl_filt_q, scl_filt_d;
  logic       sda_filt_q, sda_filt_d;

  // Sample window and majority vote; a single-clock pulse cannot win the vote.
  always_comb begin
    scl_win_d  = {scl_win_q[1:0], scl_sync_q[1]};
    sda_win_d  = {sda_win_q[1:0], sda_sync_q[1]};
    scl_filt_d = maj3(scl_win_q);
    sda_filt_d = maj3(sda_win_q);
  end

  // Filter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_win_q  <= 3'b111;
      sda_win_q  <= 3'b111;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_win_q  <= scl_win_d;
      sda_win_q  <= sda_win_d;
      scl_filt_q <= scl_filt_d;
      sda_filt_q <= sda_filt_d;
    end
  end

  assign scl_cur = scl_filt_q;
  assign sda_cur = sda_filt_q;
`else
  assign scl_cur = scl_sync_q[1];
  assign sda_cur = sda_sync_q[1];
`endif

  // Previous-sample capture for edge detection.
  always_comb begin
    scl_prev_d = scl_cur;
    sda_prev_d = sda_cur;
  end

  // Previous-sample registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  // SDA edges only count as START/STOP while SCL has been high for both samples.
  assign sda_lvl   = sda_cur;
  assign scl_rise  = scl_cur & ~scl_prev_q;
  assign scl_fall  = ~scl_cur & scl_prev_q;
  assign start_det = scl_cur & scl_prev_q & sda_prev_q & ~sda_cur;
  assign stop_det  = scl_cur & scl_prev_q & ~sda_prev_q & sda_cur;

endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: 7-bit-address I2C target with an 8-bit register pointer.
// Write: addr+W, pointer, data... ; read: addr+W, pointer, Sr, addr+R, data...
// SDA is only ever driven low or released; drive changes on SCL falling edges.
// Optional input glitch filter: define I2C_SLV_GLITCH_FILTER_EN.
`timescale 1ns/1ps
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h68,
  parameter logic [7:0] PTR_RESET  = 8'h00
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               scl,
  inout  wire                sda,
  i2c_slave_if.master        reg_if,
  output logic               busy,
  output logic               stop_seen
);

  logic sda_lvl, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl),
    .sda_in    (sda),
    .sda_lvl   (sda_lvl),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic       ack_drv_q, ack_drv_d;   // ACK slot: 0 = waiting for first fall, 1 = driving
  logic       sda_oe_q, sda_oe_d;     // 1 = pull SDA low
  logic       busy_q, busy_d;
  logic       stop_seen_q, stop_seen_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       rd_req_q, rd_req_d;
  logic [7:0] rd_addr_q, rd_addr_d;
  logic       rd_pend_q, rd_pend_d;   // read data arrives this cycle

  // Next-state and output logic; STOP, then START, override bit-level work.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    ack_drv_d   = ack_drv_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    stop_seen_d = 1'b0;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_req_d    = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_pend_d   = rd_req_q;

    if (rd_pend_q) shift_d = reg_if.reg_rd_data;

    if (stop_det) begin
      state_d     = IDLE;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      stop_seen_d = 1'b1;
      ack_drv_d   = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      ack_drv_d = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              rw_d      = sda_lvl;
              if (shift_q[6:0] == SLAVE_ADDR) begin
                state_d   = ADDR_ACK;
                busy_d    = 1'b1;
                ack_drv_d = 1'b0;
                if (sda_lvl == RW_READ) begin
                  rd_req_d  = 1'b1;
                  rd_addr_d = ptr_q;
                end
              end else begin
                state_d = WAIT_STOP;
                busy_d  = 1'b0;
              end
            end
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_drv_q) begin
              sda_oe_d  = 1'b1;
              ack_drv_d = 1'b1;
            end else begin
              ack_drv_d = 1'b0;
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              if (state_q == ADDR_ACK && rw_q == RW_READ) begin
                // First read bit goes out on the same fall that ends the ACK.
                state_d   = RDATA;
                sda_oe_d  = ~shift_q[7];
                shift_d   = {shift_q[6:0], 1'b0};
                bit_cnt_d = 4'd1;
              end else if (state_q == ADDR_ACK) begin
                state_d = PTR;
              end else if (state_q == PTR_ACK) begin
                state_d = WDATA;
              end else begin
                state_d   = WDATA;
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = shift_q;
                ptr_d     = ptr_q + 8'd1;
              end
            end
          end
        end
        PTR, WDATA: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              ack_drv_d = 1'b0;
              if (state_q == PTR) begin
                ptr_d   = {shift_q[6:0], sda_lvl};
                state_d = PTR_ACK;
              end else begin
                state_d = WDATA_ACK;
              end
            end
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = RDATA_ACK;
            end else begin
              sda_oe_d  = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_lvl == I2C_ACK) begin
              ptr_d     = ptr_q + 8'd1;
              rd_req_d  = 1'b1;
              rd_addr_d = ptr_q + 8'd1;
              bit_cnt_d = 4'd0;
              state_d   = RDATA;
            end else begin
              state_d = WAIT_STOP;
              busy_d  = 1'b0;
            end
          end
        end
        default: begin
          // IDLE and WAIT_STOP only react to START/STOP.
        end
      endcase
    end
  end

  // State and datapath registers; reset releases SDA immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      ptr_q       <= PTR_RESET;
      rw_q        <= RW_WRITE;
      ack_drv_q   <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      stop_seen_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 8'h00;
      wr_data_q   <= 8'h00;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= 8'h00;
      rd_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      ack_drv_q   <= ack_drv_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      stop_seen_q <= stop_seen_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      rd_pend_q   <= rd_pend_d;
    end
  end

  assign sda                = sda_oe_q ? 1'b0 : 1'bz;
  assign busy               = busy_q;
  assign stop_seen          = stop_seen_q;
  assign reg_if.reg_wr_en   = wr_en_q;
  assign reg_if.reg_wr_addr = wr_addr_q;
  assign reg_if.reg_wr_data = wr_data_q;
  assign reg_if.reg_rd_req  = rd_req_q;
  assign reg_if.reg_rd_addr = rd_addr_q;
  assign reg_if.dbg_state   = state_q;

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: directed bit-banged I2C master against i2c_slave with a
// small register-file model (unwritten locations read as addr ^ 8'h1D).
`timescale 1ns/1ps
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam int Q = 6;  // clocks per quarter SCL period (SCL = clk/24)

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #10 clk = ~clk;
  logic rst_n;
  logic scl_drv;
  logic m_low;
  wire  sda;
  logic busy, stop_seen;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_if reg_if ();

  i2c_slave #(.SLAVE_ADDR(7'h68), .PTR_RESET(8'h00)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl       (scl_drv),
    .sda       (sda),
    .reg_if    (reg_if),
    .busy      (busy),
    .stop_seen (stop_seen)
  );

  // ---------------- register file model ----------------
  logic [7:0] mem [256];
  bit         written [256];
  logic [7:0] rd_data_r = 8'h00;
  always @(posedge clk) begin
    if (reg_if.reg_wr_en) begin
      mem[reg_if.reg_wr_addr]     <= reg_if.reg_wr_data;
      written[reg_if.reg_wr_addr] <= 1'b1;
    end
    if (reg_if.reg_rd_req)
      rd_data_r <= written[reg_if.reg_rd_addr] ? mem[reg_if.reg_rd_addr]
                                               : (reg_if.reg_rd_addr ^ 8'h1D);
  end
  assign reg_if.reg_rd_data = rd_data_r;

  // ---------------- monitors ----------------
  logic [15:0] wr_log [$];
  logic [7:0]  rd_log [$];
  int stop_cnt = 0, busy_hi_cnt = 0, slv_low_cnt = 0;
  always @(negedge clk) begin
    if (reg_if.reg_wr_en) wr_log.push_back({reg_if.reg_wr_addr, reg_if.reg_wr_data});
    if (reg_if.reg_rd_req) rd_log.push_back(reg_if.reg_rd_addr);
    if (stop_seen) stop_cnt++;
    if (busy) busy_hi_cnt++;
    if (!m_low && sda === 1'b0) slv_low_cnt++;
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q [$];
  int pass_cnt = 0, chk_cnt = 0, fail_cnt = 0;
  int wr_base = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rd_at(input int i);
    if (i < rd_log.size()) return rd_log[i];
    return 8'hxx;
  endfunction

  task automatic check_writes(input string tag);
    logic [15:0] e, got;
    check({tag, "_wr_cnt"}, wr_log.size() - wr_base, exp_q.size());
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = (wr_base < wr_log.size()) ? wr_log[wr_base] : 16'hxxxx;
      check({tag, "_wr"}, got, e);
      wr_base++;
    end
    wr_base = wr_log.size();
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_q();
    repeat (Q) @(posedge clk);
    #2;
  endtask

  task automatic i2c_start();
    m_low = 1'b0; wait_q();
    scl_drv = 1'b1; wait_q();
    m_low = 1'b1; wait_q();
    scl_drv = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; wait_q();
    scl_drv = 1'b1; wait_q();
    m_low = 1'b0; wait_q();
    wait_q();
  endtask

  task automatic send_bit(input logic b);
    m_low = !b; wait_q();
    scl_drv = 1'b1; wait_q();
    wait_q();
    scl_drv = 1'b0; wait_q();
  endtask

  task automatic recv_bit(output logic b);
    m_low = 1'b0; wait_q();
    scl_drv = 1'b1; wait_q();
    b = sda; wait_q();
    scl_drv = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  logic       ack;
  logic [7:0] d;
  int         base_a, base_b, base_c, rd_base;
  logic [7:0] bw_data [3];
  logic [7:0] br_exp  [3];

  initial begin
    bw_data = '{8'h11, 8'h22, 8'h33};
    br_exp  = '{8'h0D, 8'h0C, 8'h0F};
    rst_n = 1'b0; scl_drv = 1'b1; m_low = 1'b0;
    repeat (5) @(posedge clk);
    #2;

    // Reset values
    check("rst_sda",       sda, 1'b1);
    check("rst_wr_en",     reg_if.reg_wr_en, 1'b0);
    check("rst_rd_req",    reg_if.reg_rd_req, 1'b0);
    check("rst_wr_addr",   reg_if.reg_wr_addr, 8'h00);
    check("rst_wr_data",   reg_if.reg_wr_data, 8'h00);
    check("rst_rd_addr",   reg_if.reg_rd_addr, 8'h00);
    check("rst_busy",      busy, 1'b0);
    check("rst_stop_seen", stop_seen, 1'b0);
    check("rst_state",     reg_if.dbg_state, IDLE);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #2;

    // T1: write 0x00 to register 0x6B
    base_a = stop_cnt;
    i2c_start();
    send_byte(8'hD0, ack); check("t1_addr_ack", ack, I2C_ACK);
    check("t1_busy", busy, 1'b1);
    send_byte(8'h6B, ack); check("t1_ptr_ack", ack, I2C_ACK);
    send_byte(8'h00, ack); check("t1_data_ack", ack, I2C_ACK);
    exp_q.push_back({8'h6B, 8'h00});
    i2c_stop();
    check("t1_stop_seen", stop_cnt - base_a, 1);
    check("t1_busy_after_stop", busy, 1'b0);
    check_writes("t1");

    // T2: read register 0x75 via repeated START, master NACKs
    rd_base = rd_log.size();
    i2c_start();
    send_byte(8'hD0, ack); check("t2_addr_w_ack", ack, I2C_ACK);
    send_byte(8'h75, ack); check("t2_ptr_ack", ack, I2C_ACK);
    i2c_start();
    send_byte(8'hD1, ack); check("t2_addr_r_ack", ack, I2C_ACK);
    recv_byte(I2C_NACK, d);
    check("t2_rdata", d, 8'h68);
    check("t2_state", reg_if.dbg_state, WAIT_STOP);
    check("t2_busy_nack", busy, 1'b0);
    check("t2_sda_released", sda, 1'b1);
    check("t2_rd_cnt", rd_log.size() - rd_base, 1);
    check("t2_rd_addr", rd_at(rd_base), 8'h75);
    base_b = slv_low_cnt;
    wait_q(); wait_q();
    check("t2_no_drive_after_nack", slv_low_cnt - base_b, 0);
    i2c_stop();

    // T3: address 0x50 mismatch
    base_a = slv_low_cnt; base_b = busy_hi_cnt; rd_base = rd_log.size();
    i2c_start();
    send_byte(8'hA0, ack); check("t3_addr_nack", ack, I2C_NACK);
    send_byte(8'h12, ack); check("t3_data_nack", ack, I2C_NACK);
    check("t3_state", reg_if.dbg_state, WAIT_STOP);
    i2c_stop();
    check("t3_sda_never_driven", slv_low_cnt - base_a, 0);
    check("t3_busy_never", busy_hi_cnt - base_b, 0);
    check("t3_no_rd", rd_log.size() - rd_base, 0);
    check_writes("t3");

    // T4: burst write from 0xFE, pointer wraps
    i2c_start();
    send_byte(8'hD0, ack); check("t4_addr_ack", ack, I2C_ACK);
    send_byte(8'hFE, ack); check("t4_ptr_ack", ack, I2C_ACK);
    for (int i = 0; i < 3; i++) begin
      send_byte(bw_data[i], ack);
      check($sformatf("t4_data_ack%0d", i), ack, I2C_ACK);
    end
    i2c_stop();
    exp_q.push_back({8'hFE, 8'h11});
    exp_q.push_back({8'hFF, 8'h22});
    exp_q.push_back({8'h00, 8'h33});
    check_writes("t4");

    // T5: burst read 3 bytes from 0x10 with ACK, ACK, NACK
    rd_base = rd_log.size();
    i2c_start();
    send_byte(8'hD0, ack); check("t5_addr_w_ack", ack, I2C_ACK);
    send_byte(8'h10, ack); check("t5_ptr_ack", ack, I2C_ACK);
    i2c_start();
    send_byte(8'hD1, ack); check("t5_addr_r_ack", ack, I2C_ACK);
    for (int i = 0; i < 3; i++) begin
      recv_byte((i == 2) ? I2C_NACK : I2C_ACK, d);
      check($sformatf("t5_rdata%0d", i), d, br_exp[i]);
    end
    wait_q(); wait_q();
    check("t5_rd_cnt", rd_log.size() - rd_base, 3);
    check("t5_rd_addr0", rd_at(rd_base),     8'h10);
    check("t5_rd_addr1", rd_at(rd_base + 1), 8'h11);
    check("t5_rd_addr2", rd_at(rd_base + 2), 8'h12);
    i2c_stop();
    check("t5_rd_cnt_after_stop", rd_log.size() - rd_base, 3);

    // T6: reset while the target drives a 0 in RDATA (reg 0x20 reads 0x3D)
    i2c_start();
    send_byte(8'hD0, ack); check("t6_addr_w_ack", ack, I2C_ACK);
    send_byte(8'h20, ack); check("t6_ptr_ack", ack, I2C_ACK);
    i2c_start();
    send_byte(8'hD1, ack); check("t6_addr_r_ack", ack, I2C_ACK);
    check("t6_state_rdata", reg_if.dbg_state, RDATA);
    check("t6_drive0", sda, 1'b0);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_sda_released", sda, 1'b1);
    check("t6_busy",      busy, 1'b0);
    check("t6_stop_seen", stop_seen, 1'b0);
    check("t6_wr_en",     reg_if.reg_wr_en, 1'b0);
    check("t6_rd_req",    reg_if.reg_rd_req, 1'b0);
    check("t6_wr_addr",   reg_if.reg_wr_addr, 8'h00);
    check("t6_wr_data",   reg_if.reg_wr_data, 8'h00);
    check("t6_rd_addr",   reg_if.reg_rd_addr, 8'h00);
    check("t6_state",     reg_if.dbg_state, IDLE);
    m_low = 1'b0; scl_drv = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b1;
    wait_q();

    // After reset the pointer is 0x00, which holds 0x33 from T4
    rd_base = rd_log.size();
    i2c_start();
    send_byte(8'hD1, ack); check("t6b_addr_r_ack", ack, I2C_ACK);
    recv_byte(I2C_NACK, d);
    check("t6b_rdata", d, 8'h33);
    check("t6b_rd_addr", rd_at(rd_base), 8'h00);
    i2c_stop();

    base_c = stop_cnt;
    i2c_start();
    send_byte(8'hD0, ack); check("t6c_addr_ack", ack, I2C_ACK);
    send_byte(8'h40, ack); check("t6c_ptr_ack", ack, I2C_ACK);
    send_byte(8'h5A, ack); check("t6c_data_ack", ack, I2C_ACK);
    i2c_stop();
    exp_q.push_back({8'h40, 8'h5A});
    check_writes("t6c");
    check("t6c_stop_seen", stop_cnt - base_c, 1);
    check("t6c_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
